// File: rtl/cs_resolve.sv
// cs_resolve: accumulates carry-save beats with a 4:2 compressor and resolves
// the group total to binary with a chunked carry-propagate adder.
module cs_resolve #(
  parameter int W     = 34,
  parameter int CHUNK = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_cs0,
  input  logic [W-1:0] in_cs1,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [7:0]   out_beats
);

  localparam int K    = (W + CHUNK - 1) / CHUNK;
  localparam int IDXW = (K > 1) ? $clog2(K) : 1;
  localparam int CW   = CHUNK + 1;

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      accS_q, accC_q;
  logic [W-1:0]      result_q;
  logic [7:0]        beatCount_q;
  logic [IDXW-1:0]   chunkIdx_q;
  logic              carry_q;

  logic [W-1:0]      s1, c1, nextS, nextC;
  logic [CW-1:0]     chunkSum;
  logic [W-1:0]      resMerged;
  logic              accept, handshake, lastChunk;

  assign accept    = (state_q == ACCUM) && in_valid;
  assign handshake = (state_q == DONE) && out_ready;
  assign lastChunk = (chunkIdx_q == IDXW'(K - 1));

  // Two cascaded 3:2 stages fold both incoming vectors into the redundant accumulator.
  always_comb begin
    s1    = accS_q ^ accC_q ^ in_cs0;
    c1    = ((accS_q & accC_q) | (accS_q & in_cs0) | (accC_q & in_cs0)) << 1;
    nextS = s1 ^ c1 ^ in_cs1;
    nextC = ((s1 & c1) | (s1 & in_cs1) | (c1 & in_cs1)) << 1;
  end

  // One chunk of the carry-propagate add; the accumulator is shifted down each
  // resolve cycle so the current chunk always sits in the low bits, and bits that
  // would land above W-1 in the final chunk fall off the W-wide merge.
  always_comb begin
    chunkSum  = {1'b0, accS_q[CHUNK-1:0]} + {1'b0, accC_q[CHUNK-1:0]} + CW'(carry_q);
    resMerged = result_q | (W'(chunkSum[CHUNK-1:0]) << (int'(chunkIdx_q) * CHUNK));
  end

  // Next-state decode for the accumulate / resolve / hold sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && in_last) state_d = RESOLVE;
      RESOLVE: if (lastChunk)         state_d = DONE;
      DONE:    if (out_ready)         state_d = ACCUM;
      default:                        state_d = ACCUM;
    endcase
  end

  // State register; reset aborts any group in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Accumulator, beat counter, chunk walker and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accS_q      <= '0;
      accC_q      <= '0;
      result_q    <= '0;
      beatCount_q <= '0;
      chunkIdx_q  <= '0;
      carry_q     <= 1'b0;
    end else begin
      if (accept) begin
        accS_q <= nextS;
        accC_q <= nextC;
        if (beatCount_q != 8'hFF) beatCount_q <= beatCount_q + 8'd1;
        if (in_last) begin
          chunkIdx_q <= '0;
          carry_q    <= 1'b0;
          result_q   <= '0;
        end
      end
      if (state_q == RESOLVE) begin
        result_q   <= resMerged;
        carry_q    <= chunkSum[CHUNK];
        accS_q     <= accS_q >> CHUNK;
        accC_q     <= accC_q >> CHUNK;
        chunkIdx_q <= chunkIdx_q + IDXW'(1);
      end
      if (handshake) begin
        accS_q      <= '0;
        accC_q      <= '0;
        beatCount_q <= '0;
      end
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = result_q;
  assign out_beats = beatCount_q;

endmodule

// File: tb/tb_cs_resolve.sv
// tb_cs_resolve: directed beats feed a scoreboard queue; a negedge monitor pops
// and compares whenever a result is handed off.
module tb_cs_resolve;

  localparam int W = 34;

  typedef struct {
    logic [W-1:0] sum;
    logic [7:0]   beats;
  } expect_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_cs0;
  logic [W-1:0] in_cs1;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [7:0]   out_beats;

  expect_t scoreboard[$];
  int testsRun  = 0;
  int failCount = 0;

  cs_resolve #(.W(W), .CHUNK(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cs0   (in_cs0),
    .in_cs1   (in_cs1),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_beats(out_beats)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic [W-1:0] sum, input logic [7:0] beats);
    expect_t e;
    e.sum   = sum;
    e.beats = beats;
    scoreboard.push_back(e);
  endtask

  task automatic waitReady();
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkOutput("readyTimeout", 64'(in_ready), 64'd1);
  endtask

  task automatic waitValid();
    int guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!out_valid) checkOutput("validTimeout", 64'(out_valid), 64'd1);
  endtask

  task automatic applyStimulus(input logic [W-1:0] cs0, input logic [W-1:0] cs1, input logic last);
    waitReady();
    in_valid = 1'b1;
    in_cs0   = cs0;
    in_cs1   = cs1;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_cs0   = '0;
    in_cs1   = '0;
  endtask

  // Monitor: every completed output handshake is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (scoreboard.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpectedResult: got sum %0h beats %0d with nothing expected", out_sum, out_beats);
      end else begin
        expect_t e;
        e = scoreboard.pop_front();
        checkOutput("outSum", 64'(out_sum), 64'(e.sum));
        checkOutput("outBeats", 64'(out_beats), 64'(e.beats));
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_cs0    = '0;
    in_cs1    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstReady", 64'(in_ready), 64'd1);
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstSum", 64'(out_sum), 64'd0);
    checkOutput("rstBeats", 64'(out_beats), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat with latency and ready profile
    pushExpect(34'h8, 8'd1);
    applyStimulus(34'h5, 34'h3, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("latencyValid%0d", i), 64'(out_valid), (i == 4) ? 64'd1 : 64'd0);
      checkOutput($sformatf("latencyReady%0d", i), 64'(in_ready), 64'd0);
    end
    waitReady();

    // Carries crossing chunk boundaries and out of the top bit
    pushExpect(34'h200, 8'd1);
    applyStimulus(34'h1FF, 34'h1, 1'b1);
    pushExpect(34'h0, 8'd1);
    applyStimulus(34'h3_FFFF_FFFF, 34'h1, 1'b1);

    // Multi-beat group with a negative term, then a fresh group
    pushExpect(34'h19, 8'd3);
    applyStimulus(34'hA, 34'h0, 1'b0);
    applyStimulus(34'h0, 34'h14, 1'b0);
    applyStimulus(34'h3_FFFF_FFFB, 34'h0, 1'b1);
    pushExpect(34'h3_FFFF_FFFE, 8'd1);
    applyStimulus(34'h3_FFFF_FFFE, 34'h0, 1'b1);

    // Backpressure in DONE with junk on the input side
    waitReady();
    out_ready = 1'b0;
    pushExpect(34'h579, 8'd1);
    applyStimulus(34'h123, 34'h456, 1'b1);
    waitValid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_cs0   = 34'h2_5555_5555;
      in_cs1   = 34'h1_2345_6789;
      in_last  = 1'b1;
      @(posedge clk); #1;
      checkOutput("holdValid", 64'(out_valid), 64'd1);
      checkOutput("holdSum", 64'(out_sum), 64'h579);
      checkOutput("holdBeats", 64'(out_beats), 64'd1);
      checkOutput("holdReady", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_cs0    = '0;
    in_cs1    = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("releaseReady", 64'(in_ready), 64'd1);
    pushExpect(34'h1, 8'd1);
    applyStimulus(34'h1, 34'h0, 1'b1);

    // Beat counter saturation
    pushExpect(34'd300, 8'd255);
    for (int i = 1; i <= 300; i++) applyStimulus(34'h1, 34'h0, (i == 300));

    // Reset during the second resolve cycle
    waitReady();
    applyStimulus(34'h55, 34'h0, 1'b1);
    @(posedge clk); #1;
    checkOutput("preResetReady", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReady", 64'(in_ready), 64'd1);
    checkOutput("midRstValid", 64'(out_valid), 64'd0);
    checkOutput("midRstSum", 64'(out_sum), 64'd0);
    checkOutput("midRstBeats", 64'(out_beats), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRstReady", 64'(in_ready), 64'd1);
    pushExpect(34'h7, 8'd1);
    applyStimulus(34'h7, 34'h0, 1'b1);

    // Drain the scoreboard
    begin
      int guard = 0;
      while (scoreboard.size() != 0 && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    checkOutput("scoreboardEmpty", 64'(scoreboard.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/cs_resolve.md
# cs_resolve

Sequential back-end for the redundant multiplier outputs. It accepts carry-save pairs (two W-bit vectors whose modular sum is the two's-complement product, sign correction already applied) and accumulates a group of them in carry-save form with a 4:2 compressor. On the last beat of a group it resolves the accumulator to a binary W-bit result with a chunked carry-propagate adder, CHUNK bits per cycle. It sits between the multiplier array and any consumer that needs a binary MAC result.

## Interface

Parameters:
- W, 34, width of each carry-save vector and of the result (N+M of the feeding multiplier).
- CHUNK, 9, bits resolved per cycle; K = ceil(W/CHUNK) resolve cycles (K=4 at defaults).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  carry-save beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_cs0  input  W  carry-save vector 0.
- in_cs1  input  W  carry-save vector 1.
- in_last  input  1  beat closes the accumulation group.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  W  resolved group sum, mod 2^W.
- out_beats  output  8  beats in the group, saturating at 255.

## Operation

- States: ACCUM, RESOLVE, DONE. Reset enters ACCUM.
- ACCUM:
  - in_ready=1. A beat is accepted on any edge with in_valid=1.
  - Accept: first 3:2 gives s1=acc_s^acc_c^in_cs0, c1=maj(acc_s,acc_c,in_cs0)<<1. Second 3:2 gives acc_s'=s1^c1^in_cs1, acc_c'=maj(s1,c1,in_cs1)<<1.
  - All vectors are truncated to W bits; carries out of bit W-1 are dropped, so arithmetic is mod 2^W.
  - beat count increments, saturating at 255.
  - in_last=1 on the accepted beat moves to RESOLVE and clears the chunk index and the carry register.
- RESOLVE:
  - in_ready=0. For i=0..K-1, one chunk per edge: {cy, res[i*CHUNK +: CHUNK]} <= acc_s[..]+acc_c[..]+cy.
  - The final chunk covers bits W-1 down to (K-1)*CHUNK only; its carry-out is discarded.
  - After chunk K-1, go to DONE: out_sum=res, out_beats=count, out_valid=1.
- DONE:
  - in_ready=0. out_valid, out_sum and out_beats are held stable until out_valid&&out_ready.
  - On the handshake: clear acc_s, acc_c and count; out_valid drops; go to ACCUM.
- in_valid and in_cs*/in_last are ignored whenever in_ready=0; nothing is queued.
- A beat with in_last=0 never produces output. The group stays open indefinitely.
- Result equals the sum of (in_cs0+in_cs1) over the group, mod 2^W, read as two's complement by the consumer.

## Timing

- Reset values (asynchronous, immediate): state=ACCUM, acc_s=acc_c=0, count=0, in_ready=1, out_valid=0, out_sum=0, out_beats=0.
- Reset in any state aborts the group; partial results are discarded.
- in_ready is a registered state decode with no combinational path from out_ready.
- Latency: the last beat is accepted at edge E0. Chunks are resolved at E1..EK, and out_valid=1 after EK, which is K cycles after acceptance (4 at defaults).
- DONE with out_ready=1 leaves at the next edge; in_ready=1 from that edge.
- Minimum period for single-beat groups is K+2 edges (6 at defaults).
- Back-to-back accumulate beats are accepted every cycle while in ACCUM.
- out_valid never drops without a handshake, except on reset.

## Test plan

- Single beat: in_cs0=34'h5, in_cs1=34'h3, in_last=1 -> out_sum=34'h8, out_beats=1, out_valid exactly 4 cycles after accept, in_ready=0 throughout RESOLVE/DONE.
- Inter-chunk carry: in_cs0=34'h1FF, in_cs1=34'h1 -> out_sum=34'h200. Then in_cs0=34'h3_FFFF_FFFF, in_cs1=34'h1 -> out_sum=0, with the carry out of bit 33 dropped.
- Accumulation with negatives: three beats (34'hA,0), (0,34'h14), (34'h3_FFFF_FFFB,0) with in_last on the third -> out_sum=34'h19, out_beats=3. A following group (34'h3_FFFF_FFFE,0) last -> out_sum=34'h3_FFFF_FFFE, confirming the accumulator is cleared.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with junk -> out_sum/out_beats/out_valid stable, in_ready=0, junk not accumulated. Release out_ready -> in_ready=1 next cycle.
- Saturation: 300 beats of (1,0), last on beat 300 -> out_sum=34'd300, out_beats=255.
- Reset mid-resolve: drop rst_n during the 2nd RESOLVE cycle -> all outputs go to reset values immediately, in_ready=1 after release. The next single-beat group (34'h7, 34'h0) -> out_sum=34'h7, out_beats=1.
